// File: rtl/otbn_tlul_host_pkg.sv
// Shared types for the OTBN TL-UL host arbiter.
package otbn_tlul_host_pkg;

  // Source IDs are sized for the largest supported requester count.
  localparam int unsigned MaxReq = 8;
  localparam int unsigned SrcW   = $clog2(MaxReq);

  localparam logic [31:0] OTBN_IMEM_OFFSET = 32'h0000_4000;
  localparam logic [31:0] OTBN_DMEM_OFFSET = 32'h0000_8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [SrcW-1:0] src;
  } host_cmd_t;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions for the single-beat, 32-bit host used by this block.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Instruction-type field set to "false" in the low nibble; everything else reserved.
  localparam logic [15:0] TL_A_USER_DEFAULT = 16'h0009;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/otbn_tlul_rr_arb.sv
// Round-robin arbiter: grants the first requester after last_grant_i, wrapping.
module otbn_tlul_rr_arb
  import otbn_tlul_host_pkg::*;
#(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [SrcW-1:0]   last_grant_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [SrcW-1:0]   idx_o
);

  logic            found_hi;
  logic            found_lo;
  logic [SrcW-1:0] idx_hi;
  logic [SrcW-1:0] idx_lo;

  // Lowest request above last_grant wins; otherwise wrap to the lowest request overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (req_i[i] && !found_hi && (i > int'(last_grant_i))) begin
        found_hi = 1'b1;
        idx_hi   = SrcW'(i);
      end
      if (req_i[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = SrcW'(i);
      end
    end
    idx_o = found_hi ? idx_hi : idx_lo;
    gnt_o = (en_i && found_lo) ? (NumReq'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/otbn_tlul_host_arb.sv
// Shares one TL-UL host port into OTBN among NumReq single-word requesters.
//
// state | meaning
// IDLE  | waiting for a command; arbiter enabled, stray D beats dropped
// ADDR  | A channel driven from the registered command until a_ready
// DATA  | waiting for d_valid; timeout counter running
// RESP  | one-cycle response pulse to the owning requester
module otbn_tlul_host_arb
  import otbn_tlul_host_pkg::*;
#(
  parameter int          NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0]        req_we_i,
  input  logic [NumReq-1:0][31:0]  req_addr_i,
  input  logic [NumReq-1:0][31:0]  req_wdata_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output tlul_pkg::tl_h2d_t        tl_o,
  input  tlul_pkg::tl_d2h_t        tl_i,
  output logic                     busy_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int unsigned     CntW    = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLoad = CntW'(TimeoutCycles - 1);

  state_e               state_q, state_d;
  host_cmd_t            cmd_q, cmd_d;
  logic [SrcW-1:0]      last_q, last_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [7:0]           drop_q, drop_d;

  logic                 arb_en;
  logic [NumReq-1:0]    arb_gnt;
  logic [SrcW-1:0]      arb_idx;
  host_cmd_t            sel_cmd;
  tlul_pkg::tl_d_op_e   exp_op;
  logic                 d_err;
  logic [NumReq-1:0]    unused_addr;
  logic                 unused_tl;

  // Holding the arbiter off while in reset keeps req_ready_o at its reset value.
  assign arb_en = (state_q == IDLE) && rst_ni;

  otbn_tlul_rr_arb #(
    .NumReq (NumReq)
  ) u_arb (
    .req_i        (req_valid_i),
    .last_grant_i (last_q),
    .en_i         (arb_en),
    .gnt_o        (arb_gnt),
    .idx_o        (arb_idx)
  );

  // Mux the granted requester's command; address is forced word-aligned.
  always_comb begin
    sel_cmd     = '0;
    unused_addr = '0;
    for (int i = 0; i < NumReq; i++) begin
      unused_addr[i] = ^req_addr_i[i][1:0];
      if (arb_gnt[i]) begin
        sel_cmd.we    = req_we_i[i];
        sel_cmd.addr  = {req_addr_i[i][31:2], 2'b00};
        sel_cmd.wdata = req_wdata_i[i];
      end
    end
    sel_cmd.src = arb_idx;
  end

  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

  assign exp_op = cmd_q.we ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
  assign d_err  = tl_i.d_error
                | (tl_i.d_source != 8'(cmd_q.src))
                | (tl_i.d_opcode != exp_op);

  // Next-state, command capture, timeout down-counter and stray-drop counter.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    drop_d  = drop_q;

    if (tl_i.d_valid && ((state_q == IDLE) || (state_q == ADDR)) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          cmd_d   = sel_cmd;
          last_d  = arb_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (tl_i.a_ready) begin
          cnt_d   = CntLoad;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tl_i.d_valid) begin
          err_d   = d_err;
          rdata_d = (!d_err && !cmd_q.we) ? tl_i.d_data : 32'h0;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      last_q  <= SrcW'(NumReq - 1);
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // A channel fields are only non-default while a beat is offered.
  always_comb begin
    tl_o         = '0;
    tl_o.a_mask  = 4'hF;
    tl_o.a_user  = tlul_pkg::TL_A_USER_DEFAULT;
    tl_o.d_ready = (state_q != RESP);
    if (state_q == ADDR) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = cmd_q.we ? tlul_pkg::PutFullData : tlul_pkg::Get;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = 8'(cmd_q.src);
      tl_o.a_address = cmd_q.addr;
      tl_o.a_data    = cmd_q.we ? cmd_q.wdata : 32'h0;
    end
  end

  assign req_ready_o = arb_gnt;
  assign rsp_valid_o = (state_q == RESP) ? (NumReq'(1) << cmd_q.src) : '0;
  assign rsp_rdata_o = (state_q == RESP) ? rdata_q : 32'h0;
  assign rsp_err_o   = (state_q == RESP) && err_q;
  assign busy_o      = (state_q != IDLE);
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_otbn_tlul_host_arb.sv
// Directed bench: stimulus pushes expected responses, a monitor pops and checks them.
module tb_otbn_tlul_host_arb;
  import tlul_pkg::*;
  import otbn_tlul_host_pkg::*;

  localparam int NR = 2;
  localparam int T  = 16;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_we;
  logic [NR-1:0][31:0]  req_addr;
  logic [NR-1:0][31:0]  req_wdata;
  logic [NR-1:0]        rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  tl_h2d_t              tl_o;
  tl_d2h_t              tl_i;
  logic                 busy;
  logic [7:0]           drop_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  otbn_tlul_host_arb #(.NumReq(NR), .TimeoutCycles(T)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .tl_o        (tl_o),
    .tl_i        (tl_i),
    .busy_o      (busy),
    .drop_cnt_o  (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic err, input logic [31:0] rdata, input int c);
    exp_t e;
    e.idx = idx; e.err = err; e.rdata = rdata; e.cyc = c;
    sb.push_back(e);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_ni && (rsp_valid != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 1 << e.idx);
        chk("rsp_err",   rsp_err,   e.err);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc,       e.cyc);
      end
    end
  end

  // Returns at the negedge of the accepting cycle, or after 20 idle cycles.
  task automatic wait_grant(output int acc, output int g, output bit got);
    got = 0; acc = 0; g = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1;
        acc = cyc;
        for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
        break;
      end
      next_cyc();
    end
  endtask

  task automatic wait_sb(input string name);
    for (int k = 0; k < T + 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk({name, "_rsp_seen"}, 0, 1);
      sb.delete();
    end
    next_cyc();
  endtask

  // One full transaction: stall a_ready for 'stall' cycles, answer after 'dwait' DATA cycles.
  task automatic run_txn(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall, input int dwait,
                         input tl_d_op_e dop, input logic derr, input logic [7:0] dsrc,
                         input logic [31:0] ddata, input logic no_rsp,
                         input logic exp_err, input logic [31:0] exp_rdata, input string name);
    int acc, g;
    bit got;
    logic [82:0] exp_a;
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    wait_grant(acc, g, got);
    if (!got) begin
      chk({name, "_accept"}, 0, 1);
      req_valid[idx] = 1'b0;
      next_cyc();
      return;
    end
    chk({name, "_ready"}, req_ready, 1 << idx);
    if (no_rsp) push_exp(idx, 1'b1, 32'h0, acc + 1 + stall + T + 1);
    else        push_exp(idx, exp_err, exp_rdata, acc + 3 + stall + dwait);
    next_cyc();
    req_valid[idx] = 1'b0;
    exp_a = {1'b1, 1'b1, (we ? 3'h0 : 3'h4), 2'd2, 8'(idx), {addr[31:2], 2'b00},
             4'hF, (we ? wdata : 32'h0)};
    for (int s = 0; s <= stall; s++) begin
      tl_i.a_ready = (s == stall);
      @(negedge clk);
      chk({name, "_achan"}, {busy, tl_o.a_valid, tl_o.a_opcode, tl_o.a_size, tl_o.a_source,
                             tl_o.a_address, tl_o.a_mask, tl_o.a_data}, exp_a);
      next_cyc();
    end
    tl_i.a_ready = 1'b0;
    if (!no_rsp) begin
      for (int w = 0; w <= dwait; w++) begin
        if (w == dwait) begin
          tl_i.d_valid  = 1'b1;
          tl_i.d_opcode = dop;
          tl_i.d_error  = derr;
          tl_i.d_source = dsrc;
          tl_i.d_data   = ddata;
        end
        @(negedge clk);
        chk({name, "_dready"}, tl_o.d_ready, 1);
        next_cyc();
      end
      tl_i.d_valid = 1'b0;
      tl_i.d_error = 1'b0;
    end
    wait_sb(name);
  endtask

  tl_h2d_t exp_tl;

  initial begin : stim
    int acc, g, prev_acc;
    bit got;
    exp_tl         = '0;
    exp_tl.a_mask  = 4'hF;
    exp_tl.a_user  = TL_A_USER_DEFAULT;
    exp_tl.d_ready = 1'b1;

    rst_ni    = 1'b0;
    req_valid = '1;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    tl_i      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tl_o",      tl_o,      exp_tl);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err",   rsp_err,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_drop",      drop_cnt,  0);
    req_valid = '0;
    next_cyc();
    rst_ni = 1'b1;
    next_cyc();

    run_txn(0, 1'b1, OTBN_DMEM_OFFSET + 32'h4, 32'hDEADBEEF, 0, 0, AccessAck, 1'b0, 8'd0,
            32'h0, 1'b0, 1'b0, 32'h0, "wr0");
    run_txn(1, 1'b0, OTBN_IMEM_OFFSET, 32'h0, 3, 2, AccessAckData, 1'b0, 8'd1,
            32'h0000_0013, 1'b0, 1'b0, 32'h0000_0013, "rd_stall");

    // Both requesters valid continuously: grants alternate, one every 4 cycles.
    req_we       = '1;
    req_addr[0]  = OTBN_DMEM_OFFSET + 32'h10;
    req_addr[1]  = OTBN_DMEM_OFFSET + 32'h14;
    req_wdata[0] = 32'h1111_0000;
    req_wdata[1] = 32'h2222_0000;
    req_valid    = '1;
    prev_acc     = 0;
    for (int t = 0; t < 4; t++) begin
      wait_grant(acc, g, got);
      if (!got) begin
        chk("fair_accept", 0, 1);
        break;
      end
      chk($sformatf("fair_grant%0d", t), g, t % 2);
      if (t > 0) chk($sformatf("fair_gap%0d", t), acc - prev_acc, 4);
      prev_acc = acc;
      push_exp(g, 1'b0, 32'h0, acc + 3);
      next_cyc();
      tl_i.a_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("fair_src%0d", t), tl_o.a_source, g);
      next_cyc();
      tl_i.a_ready  = 1'b0;
      tl_i.d_valid  = 1'b1;
      tl_i.d_opcode = AccessAck;
      tl_i.d_source = 8'(g);
      tl_i.d_error  = 1'b0;
      next_cyc();
      tl_i.d_valid = 1'b0;
      if (t == 3) req_valid = '0;
    end
    req_valid = '0;
    wait_sb("fair");

    run_txn(0, 1'b0, OTBN_DMEM_OFFSET + 32'h13, 32'h0, 0, 0, AccessAck, 1'b0, 8'd0,
            32'h5555_AAAA, 1'b0, 1'b1, 32'h0, "err_op");
    run_txn(1, 1'b1, OTBN_DMEM_OFFSET + 32'h8, 32'h1234_5678, 0, 1, AccessAck, 1'b1, 8'd1,
            32'h0, 1'b0, 1'b1, 32'h0, "err_derr");
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1, 0, AccessAckData, 1'b0, 8'd1,
            32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0, "err_src");

    run_txn(0, 1'b0, OTBN_DMEM_OFFSET, 32'h0, 0, 0, AccessAckData, 1'b0, 8'd0,
            32'h0, 1'b1, 1'b1, 32'h0, "timeout");
    chk("stray_before", drop_cnt, 0);
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = AccessAckData;
    tl_i.d_source = 8'd0;
    tl_i.d_data   = 32'hBAD0_0001;
    next_cyc();
    tl_i.d_valid = 1'b0;
    @(negedge clk);
    chk("stray_drop", drop_cnt, 1);
    chk("stray_idle", busy, 0);
    next_cyc();

    // Reset while in DATA: outputs return to reset values immediately.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = OTBN_DMEM_OFFSET;
    wait_grant(acc, g, got);
    chk("mr_grant_pre", g, 0);
    next_cyc();
    req_valid    = '0;
    tl_i.a_ready = 1'b1;
    next_cyc();
    tl_i.a_ready = 1'b0;
    next_cyc();
    chk("mr_busy", busy, 1);
    req_valid = '1;
    rst_ni    = 1'b0;
    #1;
    chk("mr_tl_o",      tl_o,      exp_tl);
    chk("mr_req_ready", req_ready, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_rsp_err",   rsp_err,   0);
    chk("mr_rsp_rdata", rsp_rdata, 0);
    chk("mr_busy_rst",  busy,      0);
    chk("mr_drop",      drop_cnt,  0);
    next_cyc();
    rst_ni = 1'b1;
    wait_grant(acc, g, got);
    chk("mr_grant_post", g, 0);
    push_exp(0, 1'b0, 32'h0000_0222, acc + 3);
    next_cyc();
    req_valid     = '0;
    tl_i.a_ready  = 1'b1;
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = AccessAckData;
    tl_i.d_source = 8'd0;
    tl_i.d_data   = 32'h0000_0111;
    next_cyc();
    tl_i.a_ready = 1'b0;
    tl_i.d_data  = 32'h0000_0222;
    next_cyc();
    tl_i.d_valid = 1'b0;
    wait_sb("mr_post");
    chk("mr_late_drop", drop_cnt, 1);

    repeat (3) next_cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
